imm_ext_unit: RTL



---
 rtl/imm_ext_pkg.sv | 11 +
 rtl/imm_ext_core.sv | 51 +++++
 rtl/imm_ext_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and field widths.
package imm_ext_pkg;

  localparam int EXT_MODE_W = 2;

  localparam logic [EXT_MODE_W-1:0] EXT_SEXT     = 2'd0;
  localparam logic [EXT_MODE_W-1:0] EXT_ZEXT     = 2'd1;
  localparam logic [EXT_MODE_W-1:0] EXT_SEXT_SHL = 2'd2;
  localparam logic [EXT_MODE_W-1:0] EXT_UPPER    = 2'd3;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extension datapath: turns a raw immediate plus mode/shift into an
// OUT_W-bit value and an overflow flag.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 24,
  parameter int SH_W  = $clog2(OUT_W)
) (
  input  logic [IN_W-1:0]       imm,
  input  logic [EXT_MODE_W-1:0] mode,
  input  logic [SH_W-1:0]       shamt,
  output logic [OUT_W-1:0]      data,
  output logic                  ovf
);

  localparam logic [SH_W:0] OUT_W_V = (SH_W + 1)'(OUT_W);

  logic signed [OUT_W-1:0] sext_val;
  logic        [OUT_W-1:0] zext_val;
  logic        [OUT_W-1:0] shl_val;
  logic signed [OUT_W-1:0] back_val;
  logic                    shamt_big;

  assign sext_val  = OUT_W'($signed(imm));
  assign zext_val  = OUT_W'(imm);
  assign shl_val   = sext_val << shamt;
  // Shifting back arithmetically recovers E only if the top shamt+1 bits were all equal.
  assign back_val  = $signed(shl_val) >>> shamt;
  assign shamt_big = {1'b0, shamt} >= OUT_W_V;

  always_comb begin
    data = '0;
    ovf  = 1'b0;
    case (mode)
      EXT_SEXT: data = sext_val;
      EXT_ZEXT: data = zext_val;
      EXT_SEXT_SHL: begin
        if (shamt_big) begin
          data = '0;
          ovf  = (sext_val != '0);
        end else begin
          data = shl_val;
          ovf  = (back_val != sext_val);
        end
      end
      default: data = zext_val << (OUT_W - IN_W);
    endcase
  end

endmodule

// File: rtl/imm_ext_unit.sv
// Immediate-extension stage with a 2-entry valid/ready output buffer so decode can
// run ahead of a stalled consumer.
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 24,
  parameter int SH_W  = $clog2(OUT_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [EXT_MODE_W-1:0] in_mode,
  input  logic [SH_W-1:0]       in_shamt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_ovf
);

  logic [OUT_W-1:0] ext_data;
  logic             ext_ovf;

  imm_ext_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SH_W (SH_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .shamt(in_shamt),
    .data (ext_data),
    .ovf  (ext_ovf)
  );

  logic [1:0]       count_reg, count_next;
  logic             rd_ptr_reg, rd_ptr_next;
  logic [OUT_W-1:0] mem_data_reg [2];
  logic             mem_ovf_reg  [2];
  logic             wr_ptr;
  logic             push, pop;

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Tail slot sits one past the head whenever a single entry is buffered.
  assign wr_ptr    = rd_ptr_reg ^ (count_reg == 2'd1);

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01: begin
        count_next  = count_reg - 2'd1;
        rd_ptr_next = ~rd_ptr_reg;
      end
      2'b11:   rd_ptr_next = ~rd_ptr_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_data_reg[gi] <= '0;
          mem_ovf_reg[gi]  <= 1'b0;
        end else if (push && (wr_ptr == 1'(gi))) begin
          mem_data_reg[gi] <= ext_data;
          mem_ovf_reg[gi]  <= ext_ovf;
        end
      end
    end
  endgenerate

  // Head payload is forced to zero while empty so stale slots never leak out.
  assign out_data = out_valid ? mem_data_reg[rd_ptr_reg] : '0;
  assign out_ovf  = out_valid ? mem_ovf_reg[rd_ptr_reg]  : 1'b0;

endmodule
